// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: scoreboard entry layout, forwarding select
// encodings and the RV32I opcodes decoded by the CPU top.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register writers (index 0 = EX .. DEPTH-1 = WB),
// with a synchronous clear and a full freeze.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         freeze_i,
    input  logic                         in_valid_i,
    input  logic [ADDR_W-1:0]            in_rd_i,
    input  logic                         in_load_i,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] rd_o,
    output logic [DEPTH-1:0]             load_o
);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0]             load_q;

    // NOTE: only valid_q strictly needs reset (rd/is_load are qualified by it),
    // but the entries are tiny so all fields reset to keep simulation X-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            rd_q    <= '0;
            load_q  <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
            rd_q    <= '0;
            load_q  <= '0;
        end else if (!freeze_i) begin
            // NOTE: non-blocking assignments make every stage shift from the
            // pre-edge values, independent of statement order.
            valid_q <= {valid_q[DEPTH-2:0], in_valid_i};
            rd_q    <= {rd_q[DEPTH-2:0], in_rd_i};
            load_q  <= {load_q[DEPTH-2:0], in_load_i};
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign load_o  = load_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: load-use stall, branch flush, external freeze,
// registered EX forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int FWD_W    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    input  logic              ext_stall_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_o,
    output logic [FWD_W-1:0]  fwd_rs1_o,
    output logic [FWD_W-1:0]  fwd_rs2_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [DEPTH-1:0]             sb_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] sb_rd;
    logic [DEPTH-1:0]             sb_load;
    logic                         sb_in_valid;

    logic [FWD_W-1:0] sel1, sel2;
    logic             lu1, lu2, hz;
    logic [FWD_W-1:0] fwd1_d, fwd1_q, fwd2_d, fwd2_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    hazard_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (~start_i),
        .freeze_i   (ext_stall_i),
        .in_valid_i (sb_in_valid),
        .in_rd_i    (id_rd_i),
        .in_load_i  (id_memread_i),
        .valid_o    (sb_valid),
        .rd_o       (sb_rd),
        .load_o     (sb_load)
    );

    // Descending scan: the last hit assigned is the lowest index (youngest producer).
    // WB is skipped because the register file writes through to ID.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel1 = FWD_W'(FWD_NONE);
        sel2 = FWD_W'(FWD_NONE);
        lu1  = 1'b0;
        lu2  = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (j != DEPTH - 1 && sb_valid[j]) begin
                if (id_rs1_used_i && id_rs1_i != '0 && sb_rd[j] == id_rs1_i) begin
                    sel1 = FWD_W'(j + 1);
                    lu1  = sb_load[j] && (j < LOAD_LAT);
                end
                if (id_rs2_used_i && id_rs2_i != '0 && sb_rd[j] == id_rs2_i) begin
                    sel2 = FWD_W'(j + 1);
                    lu2  = sb_load[j] && (j < LOAD_LAT);
                end
            end
        end
    end

    assign hz       = lu1 | lu2;
    assign flush_o  = start_i & branch_taken_i;
    assign stall_o  = start_i & (ext_stall_i | (hz & ~branch_taken_i));
    assign bubble_o = start_i & ~ext_stall_i & (branch_taken_i | hz);

    assign sb_in_valid = id_regwrite_i & (id_rd_i != '0) & ~bubble_o;

    always_comb begin
        fwd1_d = fwd1_q;
        fwd2_d = fwd2_q;
        if (!start_i) begin
            fwd1_d = '0;
            fwd2_d = '0;
        end else if (!ext_stall_i) begin
            fwd1_d = bubble_o ? '0 : sel1;
            fwd2_d = bubble_o ? '0 : sel2;
        end
    end

    assign cnt_d = (stall_o && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd1_q <= '0;
            fwd2_q <= '0;
            cnt_q  <= '0;
        end else begin
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fwd_rs1_o   = fwd1_q;
    assign fwd_rs2_o   = fwd2_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding distances, load-use stall,
// branch priority, external freeze, run-enable clear, async reset, counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk, rst, start;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, regwrite, memread;
    logic       branch, ext;

    logic       stall, bubble, flush;
    logic [1:0] fwd1, fwd2;
    logic [15:0] cnt;

    logic       stall_b, bubble_b, flush_b;
    logic [1:0] fwd1_b, fwd2_b;
    logic [1:0] cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .id_rd_i(rd), .id_regwrite_i(regwrite), .id_memread_i(memread),
        .branch_taken_i(branch), .ext_stall_i(ext),
        .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
        .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2), .stall_cnt_o(cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .id_rd_i(rd), .id_regwrite_i(regwrite), .id_memread_i(memread),
        .branch_taken_i(branch), .ext_stall_i(ext),
        .stall_o(stall_b), .bubble_o(bubble_b), .flush_o(flush_b),
        .fwd_rs1_o(fwd1_b), .fwd_rs2_o(fwd2_b), .stall_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                          input logic u2, input logic [4:0] d, input logic rw, input logic mr);
        rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
        rd = d; regwrite = rw; memread = mr;
    endtask

    task automatic nop();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; branch = 1'b0; ext = 1'b0;
        nop();
        #1 rst = 1'b1;
        #2;
        check("rst_fwd1", 32'(fwd1), 0);
        check("rst_fwd2", 32'(fwd2), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_stall", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        tick();

        // 1: ALU->ALU forwarding at distance 1, 2 and 3
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);          // add x5,x1,x2
        tick();
        set_id(5'd5, 1, 5'd3, 1, 5'd6, 1, 0);          // sub x6,x5,x3
        #1;
        check("t1_no_stall", 32'(stall), 0);
        check("t1_no_bubble", 32'(bubble), 0);
        tick();
        check("t1_fwd1_mem", 32'(fwd1), 1);
        check("t1_fwd2_none", 32'(fwd2), 0);
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        nop();
        tick();
        set_id(5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        tick();
        check("t1_fwd1_wb", 32'(fwd1), 2);
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        nop();
        tick();
        tick();
        set_id(5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        tick();
        check("t1_fwd1_regfile", 32'(fwd1), 0);

        // 2: load-use stalls one cycle, then forwards from WB-side stage
        drain();
        set_id(5'd0, 1, 5'd0, 0, 5'd5, 1, 1);          // lw x5,0(x0)
        tick();
        set_id(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);          // add x6,x5,x5
        #1;
        check("t2_stall", 32'(stall), 1);
        check("t2_bubble", 32'(bubble), 1);
        check("t2_flush", 32'(flush), 0);
        tick();
        check("t2_bubble_fwd1", 32'(fwd1), 0);
        check("t2_stall_gone", 32'(stall), 0);
        check("t2_cnt", 32'(cnt), 1);
        tick();
        check("t2_fwd1", 32'(fwd1), 2);
        check("t2_fwd2", 32'(fwd2), 2);

        // 3: x0 never tracked; youngest of two x5 writers wins
        drain();
        set_id(5'd0, 1, 5'd0, 0, 5'd0, 1, 0);          // addi x0,x0,1
        tick();
        set_id(5'd0, 1, 5'd0, 1, 5'd6, 1, 0);          // add x6,x0,x0
        #1;
        check("t3_x0_stall", 32'(stall), 0);
        tick();
        check("t3_x0_fwd1", 32'(fwd1), 0);
        check("t3_x0_fwd2", 32'(fwd2), 0);
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        tick();
        check("t3_youngest", 32'(fwd1), 1);

        // 4: taken branch overrides load-use stall
        drain();
        set_id(5'd0, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_id(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        branch = 1'b1;
        #1;
        check("t4_flush", 32'(flush), 1);
        check("t4_bubble", 32'(bubble), 1);
        check("t4_stall", 32'(stall), 0);
        tick();
        branch = 1'b0;
        check("t4_cnt", 32'(cnt), 1);
        check("t4_fwd1", 32'(fwd1), 0);
        nop();
        tick();
        set_id(5'd6, 1, 5'd6, 1, 5'd7, 1, 0);          // sub x7,x6,x6
        tick();
        check("t4_not_recorded", 32'(fwd1), 0);

        // 5: external freeze for 4 cycles in a dependency chain
        drain();
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);          // add x5,x1,x2
        tick();
        set_id(5'd5, 1, 5'd3, 1, 5'd6, 1, 0);          // sub x6,x5,x3
        tick();
        check("t5_pre_fwd1", 32'(fwd1), 1);
        set_id(5'd6, 1, 5'd5, 1, 5'd7, 1, 0);          // and x7,x6,x5
        ext = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_ext_stall", 32'(stall), 1);
            check("t5_ext_bubble", 32'(bubble), 0);
            tick();
            check("t5_hold_fwd1", 32'(fwd1), 1);
            check("t5_hold_fwd2", 32'(fwd2), 0);
        end
        ext = 1'b0;
        #1;
        check("t5_resume_stall", 32'(stall), 0);
        tick();
        check("t5_resume_fwd1", 32'(fwd1), 1);
        check("t5_resume_fwd2", 32'(fwd2), 2);
        check("t5_cnt", 32'(cnt), 5);

        // run-enable low: outputs forced off, state cleared, counter held
        start = 1'b0;
        ext = 1'b1;
        #1;
        check("start0_stall", 32'(stall), 0);
        tick();
        check("start0_fwd1", 32'(fwd1), 0);
        check("start0_fwd2", 32'(fwd2), 0);
        check("start0_cnt", 32'(cnt), 5);
        start = 1'b1;
        ext = 1'b0;
        set_id(5'd7, 1, 5'd6, 1, 5'd8, 1, 0);          // sub x8,x7,x6
        tick();
        check("start0_cleared", 32'(fwd1), 0);

        // 6: asynchronous reset in the middle of a load-use stall
        drain();
        set_id(5'd0, 1, 5'd0, 0, 5'd5, 1, 1);
        tick();
        set_id(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        #1;
        check("t6_pre_stall", 32'(stall), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_stall", 32'(stall), 0);
        check("t6_rst_bubble", 32'(bubble), 0);
        check("t6_rst_cnt", 32'(cnt), 0);
        check("t6_rst_fwd1", 32'(fwd1), 0);
        #1 rst = 1'b0;
        nop();
        tick();

        // 6b: 2-bit counter saturates at 3
        ext = 1'b1;
        repeat (3) tick();
        check("sat_at3", 32'(cnt_b), 3);
        repeat (2) tick();
        check("sat_hold", 32'(cnt_b), 3);
        check("wide_cnt5", 32'(cnt), 5);
        ext = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Takes ID-stage register usage as input.
- Keeps an internal scoreboard of in-flight writers in EX..WB.
- Generates the stall, bubble and flush controls and the registered EX-stage forwarding selects that the current pipeline ties off (Flush=0, PCWrite=1).
- Also counts stall cycles for performance monitoring.

Parameters:
ADDR_W, 5, register address width
DEPTH, 3, tracked stages after ID (index 0=EX, 1=MEM, ... DEPTH-1=WB); DEPTH>=2
LOAD_LAT, 1, a load at scoreboard index j < LOAD_LAT cannot yet forward, so a dependent ID instruction stalls
CNT_W, 16, stall counter width
FWD_W, $clog2(DEPTH), forwarding select width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  pipeline run enable
id_rs1_i  in  ADDR_W  ID rs1 address
id_rs2_i  in  ADDR_W  ID rs2 address
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
id_rd_i  in  ADDR_W  ID destination address
id_regwrite_i  in  1  ID instruction writes rd
id_memread_i  in  1  ID instruction is a load
branch_taken_i  in  1  taken branch resolved in EX
ext_stall_i  in  1  multi-cycle unit busy; freeze whole pipeline
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  zero ID/EX control signals
flush_o  out  1  clear IF/ID
fwd_rs1_o  out  FWD_W  EX rs1 source: 0=ID/EX data, k=stage k (1=MEM, 2=WB...)
fwd_rs2_o  out  FWD_W  as above for rs2
stall_cnt_o  out  CNT_W  saturating count of stall_o cycles

Behaviour:
- Reset (async, rst_i=1): all scoreboard entries invalid; fwd_rs1_o, fwd_rs2_o and stall_cnt_o = 0. Combinational outputs evaluate to 0 because entries are invalid.
- Scoreboard entry fields: {valid, rd, is_load}.
- Writes with rd==0 are never recorded. A source address of 0 never matches.
- Match for rsX: the source is used, entry j is valid, and entry.rd==rsX, for j in 0..DEPTH-2. Index DEPTH-1 (WB) is resolved by register-file write-through and is never matched.
- Multiple matches: the lowest index (youngest producer) wins.
- Load-use stall: hz = any winning match at index j with is_load and j < LOAD_LAT.
- Combinational outputs, all forced to 0 when start_i=0:
  - flush_o = branch_taken_i
  - stall_o = ext_stall_i | (hz & ~branch_taken_i)
  - bubble_o = ~ext_stall_i & (branch_taken_i | hz)
- Priority: ext_stall_i > branch_taken_i > hz.
- Sequential update, rising edge, when start_i=1:
  - ext_stall_i=1: scoreboard, fwd_* hold (full freeze).
  - Otherwise, shift: entry[k+1] <= entry[k]; entry[0] <= {id_regwrite_i & rd!=0 & ~bubble_o, id_rd_i, id_memread_i}.
  - fwd_rsX_o <= bubble_o ? 0 : (winning match at index j ? j+1 : 0). The value is valid during the EX cycle of the consumer.
- start_i=0: synchronous clear of all entries and fwd_*. stall_cnt_o holds.
- stall_cnt_o increments each cycle stall_o=1 and saturates at all-ones (no wrap).
- Reset mid-operation: immediate return to reset state. No pending stall survives.

Decomposition:
- Shared package pipe_pkg holds:
  - sb_entry_t {valid, rd, is_load}
  - FWD_NONE=0, FWD_MEM=1, FWD_WB=2
  - the opcode parameters already used by the CPU top
- One sub-module, hazard_scoreboard: a DEPTH-entry shift register with freeze/clear, exposing all entries.
- Match/priority logic and the counter live in pipe_hazard_ctrl.

Test Plan:
1. add x5,x1,x2 then sub x6,x5,x3 → no stall; sub in EX sees fwd_rs1_o=1. With one nop between them, fwd_rs1_o=2. With two nops, 0.
2. lw x5,0(x0) then add x6,x5,x5 → stall_o=1 and bubble_o=1 for exactly 1 cycle; next cycle add in EX has fwd_rs1_o=fwd_rs2_o=2. stall_cnt_o=1.
3. addi x0,x0,1 then add x6,x0,x0 → no stall, fwd=0. Also, x5 written at index 0 and index 1 simultaneously → fwd selects 1.
4. branch_taken_i=1 coincident with a load-use hazard → flush_o=1, bubble_o=1, stall_o=0. The dependent instruction is not recorded. Counter unchanged.
5. ext_stall_i=1 for 4 cycles during a dependency chain → stall_o=1, bubble_o=0, scoreboard and fwd values unchanged. Resume gives the same forwarding as an unstalled run. Counter +4.
6. rst_i asserted mid-stall (asynchronous, between edges) → outputs 0 immediately. Also with CNT_W=2: force 5 stall cycles → stall_cnt_o saturates at 3.
